// File: rtl/cic_comp_fir.sv
// cic_comp_fir: symmetric CIC droop-compensation FIR with one time-shared
// multiplier. Each accepted sample starts H MAC steps, then a rounding cycle.
// Optional macro CIC_COMP_SATURATE_EN: clamp the rounded result to the OUT_DW
// range instead of wrapping.
module cic_comp_fir #(
  parameter int unsigned INP_DW    = 18,
  parameter int unsigned OUT_DW    = 18,
  parameter int unsigned COEF_DW   = 18,
  parameter int unsigned NUM_TAPS  = 21,
  parameter logic [COEF_DW*((NUM_TAPS+1)/2)-1:0] COEFS = '0,
  parameter int unsigned OUT_SHIFT = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [INP_DW-1:0] s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  output logic              overrun
);

  localparam int unsigned H       = (NUM_TAPS + 1) / 2;
  localparam int unsigned KW      = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned PRE_DW  = INP_DW + 1;
  localparam int unsigned PROD_DW = PRE_DW + COEF_DW;
  localparam int unsigned ACC_DW  = INP_DW + 1 + COEF_DW + $clog2(H);
  localparam int unsigned XW      = INP_DW * NUM_TAPS;
  localparam int unsigned RND_POS = (OUT_SHIFT > 0) ? (OUT_SHIFT - 1) : 0;
  localparam logic signed [ACC_DW:0] RND_ADD =
    (OUT_SHIFT > 0) ? ((ACC_DW + 1)'(1) << RND_POS) : '0;

  typedef enum logic [1:0] {IDLE, MAC, RND} state_t;

  state_t                     state_q, state_d;
  logic [XW-1:0]              x_q, x_d;
  logic signed [ACC_DW-1:0]   acc_q, acc_d;
  logic [KW-1:0]              k_q, k_d;
  logic [OUT_DW-1:0]          out_q, out_d;
  logic                       vld_q, vld_d;
  logic                       ovr_q, ovr_d;

  logic signed [INP_DW-1:0]   x_lo, x_hi;
  logic signed [COEF_DW-1:0]  coef;
  logic signed [PRE_DW-1:0]   pre;
  logic signed [PROD_DW-1:0]  prod;
  logic signed [ACC_DW:0]     rnd_sum;
  logic [OUT_DW-1:0]          res;
  logic                       accept;

  // Current MAC term: coefficient times the pre-added symmetric tap pair
  always_comb begin
    x_lo = $signed(x_q[INP_DW*k_q +: INP_DW]);
    x_hi = $signed(x_q[INP_DW*(NUM_TAPS-1-k_q) +: INP_DW]);
    coef = $signed(COEFS[COEF_DW*k_q +: COEF_DW]);
    if (k_q == KW'(H - 1)) begin
      pre = PRE_DW'(x_lo);
    end else begin
      pre = PRE_DW'(x_lo) + PRE_DW'(x_hi);
    end
    prod = PROD_DW'(pre) * PROD_DW'(coef);
  end

`ifdef CIC_COMP_SATURATE_EN
  localparam logic signed [ACC_DW:0] SAT_HI = (ACC_DW + 1)'({1'b0, {(OUT_DW-1){1'b1}}});
  localparam logic signed [ACC_DW:0] SAT_LO = ~SAT_HI;
  logic signed [ACC_DW:0] rnd_sh;

  // Round half-up, shift, then clamp to the output range
  always_comb begin
    rnd_sum = (ACC_DW + 1)'(acc_q) + RND_ADD;
    rnd_sh  = rnd_sum >>> OUT_SHIFT;
    if (rnd_sh > SAT_HI) begin
      res = {1'b0, {(OUT_DW-1){1'b1}}};
    end else if (rnd_sh < SAT_LO) begin
      res = {1'b1, {(OUT_DW-1){1'b0}}};
    end else begin
      res = rnd_sh[OUT_DW-1:0];
    end
  end
`else
  // Round half-up, shift, then keep the low bits (two's-complement wrap)
  always_comb begin
    rnd_sum = (ACC_DW + 1)'(acc_q) + RND_ADD;
    res     = OUT_DW'(rnd_sum >>> OUT_SHIFT);
  end
`endif

  // Next-state logic: sample acceptance, MAC sequencing, output strobe
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    k_d     = k_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    ovr_d   = ovr_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_axis_in_tvalid) accept = 1'b1;
      end
      MAC: begin
        acc_d = acc_q + ACC_DW'(prod);
        k_d   = k_q + KW'(1);
        if (s_axis_in_tvalid) ovr_d = 1'b1;
        if (k_q == KW'(H - 1)) begin
          k_d     = '0;
          state_d = RND;
        end
      end
      RND: begin
        out_d = res;
        vld_d = 1'b1;
        if (s_axis_in_tvalid) accept = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      x_d     = {x_q[XW-INP_DW-1:0], s_axis_in_tdata};
      acc_d   = '0;
      k_d     = '0;
      state_d = MAC;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign m_axis_out_tdata  = out_q;
  assign m_axis_out_tvalid = vld_q;
  assign overrun           = ovr_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: 5 taps, coefficients 1,2,4.
// Instance A: OUT_DW=18, OUT_SHIFT=2. Instance B: OUT_DW=8, OUT_SHIFT=0.
module tb_cic_comp_fir;

  localparam int unsigned LAT = 5; // H+2 edges from input strobe to output strobe
  localparam logic [53:0] COEFS = {18'sd4, 18'sd2, 18'sd1};

  typedef struct {
    int y;
    int cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [17:0] a_in = '0;
  logic               a_vin = 1'b0;
  logic [17:0]        a_dat;
  logic               a_vld;
  logic               a_ovr;
  logic signed [17:0] b_in = '0;
  logic               b_vin = 1'b0;
  logic [7:0]         b_dat;
  logic               b_vld;
  logic               b_ovr;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  // Impulse plus rounding vectors, 10 clocks apart
  int s1_d[21] = '{4, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0,  -2, 0, 0, 0, 0,  -3, 0, 0, 0, 0};
  int s1_y[21] = '{1, 2, 4, 2, 1, 0,  1, 1, 2, 1, 1,   0, -1, -2, -1, 0, -1, -1, -3, -1, -1};
  // Tight spacing: gap is clocks until the next strobe; entry 3 is dropped
  int s2_d[7]   = '{4, 0, 0, 100, 0, 0, 0};
  int s2_gap[7] = '{4, 4, 3, 7,   4, 4, 10};
  bit s2_acc[7] = '{1, 1, 1, 0,   1, 1, 1};
  int s2_y[7]   = '{1, 2, 4, 0,   2, 1, 0};
  // Step of 100 into the 8-bit instance: raw 100,300,700,900,1000
`ifdef CIC_COMP_SATURATE_EN
  int b_y[5] = '{100, 127, 127, 127, 127};
`else
  int b_y[5] = '{100, 44, -68, -124, -24};
`endif

  cic_comp_fir #(
    .INP_DW(18), .OUT_DW(18), .COEF_DW(18), .NUM_TAPS(5),
    .COEFS(COEFS), .OUT_SHIFT(2)
  ) u_a (
    .clk(clk), .reset_n(reset_n),
    .s_axis_in_tdata(a_in), .s_axis_in_tvalid(a_vin),
    .m_axis_out_tdata(a_dat), .m_axis_out_tvalid(a_vld), .overrun(a_ovr)
  );

  cic_comp_fir #(
    .INP_DW(18), .OUT_DW(8), .COEF_DW(18), .NUM_TAPS(5),
    .COEFS(COEFS), .OUT_SHIFT(0)
  ) u_b (
    .clk(clk), .reset_n(reset_n),
    .s_axis_in_tdata(b_in), .s_axis_in_tvalid(b_vin),
    .m_axis_out_tdata(b_dat), .m_axis_out_tvalid(b_vld), .overrun(b_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected entry whenever an instance strobes an output
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_vld) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected: got output %0d, expected no output (cycle %0d)",
                   $signed(a_dat), cyc);
        end else begin
          e = qa.pop_front();
          chk("a_data", int'($signed(a_dat)), e.y);
          chk("a_cycle", cyc, e.cyc);
        end
      end
      if (b_vld) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected: got output %0d, expected no output (cycle %0d)",
                   $signed(b_dat), cyc);
        end else begin
          e = qb.pop_front();
          chk("b_data", int'($signed(b_dat)), e.y);
          chk("b_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  // Strobe one sample into A at a negedge, then idle until the next slot
  task automatic send_a(input int d, input int gap, input bit acc, input int y);
    exp_t e;
    a_in  = 18'(d);
    a_vin = 1'b1;
    if (acc) begin
      e.y = y; e.cyc = cyc + LAT;
      qa.push_back(e);
    end
    @(negedge clk);
    a_vin = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_b(input int d, input int gap, input int y);
    exp_t e;
    b_in  = 18'(d);
    b_vin = 1'b1;
    e.y = y; e.cyc = cyc + LAT;
    qb.push_back(e);
    @(negedge clk);
    b_vin = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_a_tdata", int'(a_dat), 0);
    chk("rst_a_tvalid", int'(a_vld), 0);
    chk("rst_a_overrun", int'(a_ovr), 0);
    chk("rst_b_tdata", int'(b_dat), 0);
    chk("rst_b_tvalid", int'(b_vld), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Impulse response and round-half-up behaviour
    for (int i = 0; i < 21; i++) send_a(s1_d[i], 10, 1'b1, s1_y[i]);
    chk("seq1_overrun", int'(a_ovr), 0);

    // H+1 spacing (accept in RND), then one sample too early
    for (int i = 0; i < 7; i++) begin
      if (!s2_acc[i]) chk("ovr_before_drop", int'(a_ovr), 0);
      send_a(s2_d[i], s2_gap[i], s2_acc[i], s2_y[i]);
      if (!s2_acc[i]) chk("ovr_after_drop", int'(a_ovr), 1);
    end
    chk("seq2_overrun_sticky", int'(a_ovr), 1);

    // Reset in the middle of MAC: result discarded, history cleared
    send_a(100, 2, 1'b0, 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_tdata", int'(a_dat), 0);
    chk("midrst_tvalid", int'(a_vld), 0);
    chk("midrst_overrun", int'(a_ovr), 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 6; i++) send_a(s1_d[i], 10, 1'b1, s1_y[i]);
    chk("post_rst_overrun", int'(a_ovr), 0);

    // Narrow output: wrap or clamp depending on build
    for (int i = 0; i < 5; i++) send_b(100, 10, b_y[i]);
    chk("b_overrun", int'(b_ovr), 0);

    // Drain with a bounded wait
    for (int i = 0; i < 100; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
